// File: rtl/punc_control_mc.sv
// Multi-cycle control FSM for the PUnC LC3 datapath: fetch/decode/execute with
// two-phase indirect loads/stores, parameterised memory wait states and a sticky halt.
module punc_control_mc #(
    parameter int DATA_W   = 16,
    parameter int MEM_WAIT = 0,
    parameter int WAIT_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] ir,
    input  logic              n,
    input  logic              z,
    input  logic              p,
    output logic              mem_w_en,
    output logic [1:0]        mem_w_addr_sel,
    output logic              mem_w_data_sel,
    output logic [1:0]        mem_r_addr_sel,
    output logic              rf_w_en,
    output logic              rf_w_addr_sel,
    output logic [1:0]        rf_w_data_sel,
    output logic              rf_r0_addr_sel,
    output logic              rf_r1_addr_sel,
    output logic              ir_ld,
    output logic              ind_ld,
    output logic              pc_ld,
    output logic              pc_clr,
    output logic              pc_inc,
    output logic [1:0]        pc_ld_data_sel,
    output logic [2:0]        alu_sel,
    output logic              cond_ld,
    output logic              cond_ld_data_sel,
    output logic              halted,
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        INIT   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        EXEC_I = 3'd4,
        HALT   = 3'd5
    } state_t;

    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_LD   = 4'b0010;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_JSR  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_LDR  = 4'b0110;
    localparam logic [3:0] OP_STR  = 4'b0111;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_LDI  = 4'b1010;
    localparam logic [3:0] OP_STI  = 4'b1011;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_LEA  = 4'b1110;
    localparam logic [3:0] OP_TRAP = 4'b1111;

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT);

    state_t            state;
    state_t            next_state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              mem_access;
    logic              last;
    logic [3:0]        opcode;
    logic              br_taken;
    logic              unused_ir;

    assign opcode    = ir[DATA_W-1 -: 4];
    assign last      = (wait_cnt == WAIT_LAST);
    assign br_taken  = (n & ir[11]) | (z & ir[10]) | (p & ir[9]);
    assign unused_ir = ^ir;

    // The wait counter only advances while a memory access is stalling and
    // restarts whenever the FSM moves to a different state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= INIT;
            wait_cnt <= '0;
        end else begin
            state <= next_state;
            if (next_state != state)
                wait_cnt <= '0;
            else if (mem_access && !last)
                wait_cnt <= wait_cnt + 1'b1;
        end
    end

    always_comb begin
        next_state       = state;
        mem_access       = 1'b0;
        mem_w_en         = 1'b0;
        mem_w_addr_sel   = 2'd0;
        mem_w_data_sel   = 1'b0;
        mem_r_addr_sel   = 2'd0;
        rf_w_en          = 1'b0;
        rf_w_addr_sel    = 1'b0;
        rf_w_data_sel    = 2'd0;
        rf_r0_addr_sel   = 1'b0;
        rf_r1_addr_sel   = 1'b0;
        ir_ld            = 1'b0;
        ind_ld           = 1'b0;
        pc_ld            = 1'b0;
        pc_clr           = 1'b0;
        pc_inc           = 1'b0;
        pc_ld_data_sel   = 2'd0;
        alu_sel          = 3'd0;
        cond_ld          = 1'b0;
        cond_ld_data_sel = 1'b0;
        halted           = 1'b0;
        state_dbg        = 3'd0;

        // Reset wins over every state so a half-finished store can never strobe.
        if (!rst) begin
            state_dbg = state;
            case (state)
                INIT: begin
                    pc_clr     = 1'b1;
                    next_state = FETCH;
                end
                FETCH: begin
                    mem_access = 1'b1;
                    if (last) begin
                        ir_ld      = 1'b1;
                        next_state = DECODE;
                    end
                end
                DECODE: begin
                    pc_inc     = 1'b1;
                    next_state = (opcode == OP_TRAP) ? HALT : EXEC;
                end
                EXEC: begin
                    next_state = FETCH;
                    case (opcode)
                        OP_ADD, OP_AND: begin
                            alu_sel = {1'b0, opcode == OP_AND, ir[5]};
                            rf_w_en = 1'b1;
                            cond_ld = 1'b1;
                        end
                        OP_NOT: begin
                            alu_sel = 3'd4;
                            rf_w_en = 1'b1;
                            cond_ld = 1'b1;
                        end
                        OP_BR: pc_ld = br_taken;
                        OP_JMP: begin
                            pc_ld          = 1'b1;
                            pc_ld_data_sel = 2'd1;
                        end
                        OP_JSR: begin
                            rf_w_en        = 1'b1;
                            rf_w_addr_sel  = 1'b1;
                            rf_w_data_sel  = 2'd3;
                            pc_ld          = 1'b1;
                            pc_ld_data_sel = ir[11] ? 2'd2 : 2'd1;
                        end
                        OP_LEA: begin
                            rf_w_en          = 1'b1;
                            rf_w_data_sel    = 2'd2;
                            cond_ld          = 1'b1;
                            cond_ld_data_sel = 1'b1;
                        end
                        OP_LD, OP_LDR: begin
                            mem_access       = 1'b1;
                            mem_r_addr_sel   = (opcode == OP_LD) ? 2'd1 : 2'd2;
                            rf_w_data_sel    = 2'd1;
                            cond_ld_data_sel = 1'b1;
                            rf_w_en          = last;
                            cond_ld          = last;
                            if (!last) next_state = EXEC;
                        end
                        OP_ST, OP_STR: begin
                            mem_access     = 1'b1;
                            mem_w_addr_sel = (opcode == OP_ST) ? 2'd0 : 2'd1;
                            rf_r0_addr_sel = 1'b1;
                            mem_w_en       = last;
                            if (!last) next_state = EXEC;
                        end
                        OP_LDI, OP_STI: begin
                            mem_access     = 1'b1;
                            mem_r_addr_sel = 2'd1;
                            ind_ld         = last;
                            next_state     = last ? EXEC_I : EXEC;
                        end
                        default: ;
                    endcase
                end
                EXEC_I: begin
                    mem_access = 1'b1;
                    next_state = last ? FETCH : EXEC_I;
                    if (opcode == OP_LDI) begin
                        mem_r_addr_sel   = 2'd3;
                        rf_w_data_sel    = 2'd1;
                        cond_ld_data_sel = 1'b1;
                        rf_w_en          = last;
                        cond_ld          = last;
                    end else if (opcode == OP_STI) begin
                        mem_w_addr_sel = 2'd2;
                        rf_r0_addr_sel = 1'b1;
                        mem_w_en       = last;
                    end
                end
                HALT: halted = 1'b1;
                default: next_state = INIT;
            endcase
        end
    end

endmodule

// File: doc/punc_control_mc.md
Name: punc_control_mc

Overview:
- Parametrised multi-cycle control FSM for the PUnC LC3 processor. Drives the datapath selects and enables from the instruction register and condition codes.
- Extends the single-cycle-execute controller with:
  - full two-phase indirect execution (LDI/STI) through an indirect-address register;
  - configurable memory wait states on every memory access;
  - a sticky HALT state and a debug state output.
- Sits between the datapath (which supplies ir and n/z/p) and the memory/register file/PC/ALU control pins.

Parameters:
- DATA_W, 16, instruction/data width. Must be >= 16. Opcode is ir[DATA_W-1:DATA_W-4]; LC3 field positions are otherwise unchanged.
- MEM_WAIT, 0, extra stall cycles per memory access (0..15).
- WAIT_W, 4, width of the wait counter. Must hold MEM_WAIT.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ir  in  DATA_W  current instruction register contents
- n, z, p  in  1 each  condition code flags from datapath
- mem_w_en  out  1  memory write strobe
- mem_w_addr_sel  out  2  0=PC+off9, 1=base+off6, 2=indirect reg
- mem_w_data_sel  out  1  0=RF r0 data
- mem_r_addr_sel  out  2  0=PC, 1=PC+off9, 2=base+off6, 3=indirect reg
- rf_w_en  out  1  register file write
- rf_w_addr_sel  out  1  0=ir[11:9], 1=R7
- rf_w_data_sel  out  2  0=ALU, 1=MEM, 2=PC+off9, 3=PC
- rf_r0_addr_sel  out  1  0=ir[8:6], 1=ir[11:9]
- rf_r1_addr_sel  out  1  0=ir[2:0], 1=ir[8:6]
- ir_ld  out  1  load IR from memory read data
- ind_ld  out  1  load indirect-address register from memory read data
- pc_ld, pc_clr, pc_inc  out  1 each  PC controls
- pc_ld_data_sel  out  2  0=PC+off9, 1=RF r0, 2=PC+off11
- alu_sel  out  3  0=ADD, 1=ADD_I, 2=AND, 3=AND_I, 4=NOT, 5=PASS
- cond_ld  out  1  load n/z/p
- cond_ld_data_sel  out  1  0=ALU result, 1=RF write data
- halted  out  1  high while in HALT
- state_dbg  out  3  current state encoding

Behaviour:
- State encoding: INIT=0, FETCH=1, DECODE=2, EXEC=3, EXEC_I=4, HALT=5.
- Reset:
  - rst high at a clk edge puts the next state in INIT and clears the wait counter.
  - While rst is high, every output is forced to 0 combinationally, from any state, including mid-EXEC_I or mid-wait.
- Output defaults: all outputs are 0 unless listed below.
- Outputs are Moore/Mealy combinational from state, ir, n/z/p and the wait counter.
- Memory stall rule:
  - Every state that reads or writes memory (FETCH; EXEC for LD/LDR/LDI/ST/STR/STI; EXEC_I) lasts MEM_WAIT+1 cycles.
  - Address selects are held for the whole stall.
  - The terminal enable (ir_ld, ind_ld, rf_w_en, cond_ld, mem_w_en) asserts only on the last cycle, when the wait counter equals MEM_WAIT.
  - The counter clears on every state change.
- INIT: pc_clr=1 for one cycle, then FETCH.
- FETCH: mem_r_addr_sel=0; ir_ld on the last cycle; then DECODE.
- DECODE: pc_inc=1 for one cycle. Next state is HALT if opcode=1111, else EXEC.
- EXEC by opcode:
  - ADD/AND: rf_w_en, cond_ld, cond_ld_data_sel=0. alu_sel selects the immediate form when ir[5]=1. One cycle.
  - NOT: alu_sel=4, rf_w_en=1, cond_ld=1. One cycle.
  - BR: pc_ld=1, sel 0, only if (n&ir[11])|(z&ir[10])|(p&ir[9]). BR with ir[11:9]=000 never loads.
  - JMP/RET: pc_ld=1, sel 1, rf_r0_addr_sel=0.
  - JSR (ir[11]=1): rf_w_en=1, rf_w_addr_sel=1 (R7), rf_w_data_sel=3, pc_ld=1, pc sel 2.
  - JSRR (ir[11]=0): as JSR but pc sel 1. R7 captures the pre-jump PC in the same cycle.
  - LEA: rf_w_en=1, rf_w_data_sel=2, cond_ld=1, cond_ld_data_sel=1.
  - LD: mem_r_addr_sel=1. LDR: mem_r_addr_sel=2. For both: rf_w_data_sel=1, rf_w_en and cond_ld (sel 1) on the last cycle.
  - ST: mem_w_addr_sel=0, rf_r0_addr_sel=1. STR: mem_w_addr_sel=1, rf_r0_addr_sel=1. For both: mem_w_en on the last cycle only.
  - LDI/STI: mem_r_addr_sel=1; ind_ld on the last cycle; then EXEC_I.
  - Unused opcode (1101): no-op.
  - All EXEC paths except LDI/STI return to FETCH.
- EXEC_I:
  - LDI: mem_r_addr_sel=3, rf_w_data_sel=1; rf_w_en and cond_ld (sel 1) on the last cycle.
  - STI: mem_w_addr_sel=2, rf_r0_addr_sel=1; mem_w_en on the last cycle.
  - Then FETCH.
- HALT: halted=1; no other outputs asserted. Remains in HALT until rst.
- mem_w_en and rf_w_en are never both high in the same cycle.
- Each enable is high for exactly one cycle per instruction.

Test Plan:
- MEM_WAIT=0, rst for 2 cycles then release -> state_dbg 0,1,2,3,1. pc_clr high exactly in cycle 1 after rst. ir_ld in FETCH. pc_inc in DECODE.
- ir=0x1261 (ADD R1,R1,#1) -> in EXEC: alu_sel=1, rf_w_en=1, cond_ld=1, rf_w_addr_sel=0. ir=0x927F (NOT) -> alu_sel=4, rf_w_en=1.
- ir=0x0402 (BRz) with z=1 -> pc_ld=1, sel 0. Same ir with z=0, n=1 -> pc_ld=0. EXEC lasts 1 cycle either way.
- MEM_WAIT=2, ir=0xA205 (LDI) -> FETCH 3 cycles, DECODE 1, EXEC 3 with ind_ld only on the 3rd, EXEC_I 3 with rf_w_en and cond_ld only on the 3rd. Total 10 cycles.
- MEM_WAIT=1, ir=0x7442 (STR) -> mem_w_en high for exactly 1 cycle, the 2nd EXEC cycle, with mem_w_addr_sel=1 and rf_r0_addr_sel=1. rf_w_en=0 throughout.
- ir=0xF025 -> DECODE to HALT; halted=1 and steady for 20 cycles. rst asserted during EXEC_I of an STI -> mem_w_en never asserts; state_dbg=0 the next cycle.
